// File: rtl/aclk_counter_if.sv
// Bus bundle for aclk_counter: tick/load requests and BCD digits in, BCD time and load_err out.
interface aclk_counter_if;
    logic       one_minute;
    logic       load_new_c;
    logic [3:0] new_current_time_ms_hr;
    logic [3:0] new_current_time_ls_hr;
    logic [3:0] new_current_time_ms_min;
    logic [3:0] new_current_time_ls_min;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic       load_err;

    modport master (
        output one_minute, load_new_c,
        output new_current_time_ms_hr, new_current_time_ls_hr,
        output new_current_time_ms_min, new_current_time_ls_min,
        input  current_time_ms_hr, current_time_ls_hr,
        input  current_time_ms_min, current_time_ls_min,
        input  load_err
    );

    modport slave (
        input  one_minute, load_new_c,
        input  new_current_time_ms_hr, new_current_time_ls_hr,
        input  new_current_time_ms_min, new_current_time_ls_min,
        output current_time_ms_hr, current_time_ls_hr,
        output current_time_ms_min, current_time_ls_min,
        output load_err
    );
endinterface

// File: rtl/aclk_counter.sv
// 24-hour BCD HH:MM time register with minute tick and load.
// Define ACLK_LOAD_CHECK_EN to reject out-of-range loads and pulse load_err.
module aclk_counter (
    input logic           clock,
    input logic           reset,
    aclk_counter_if.slave bus
);

    logic [3:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
    logic       r_load_err;

    logic [3:0] w_inc_ms_hr, w_inc_ls_hr, w_inc_ms_min, w_inc_ls_min;
    logic       w_load_ok;

    // >= compares let any illegal digit collapse to a legal value on the next tick
    always_comb begin
        w_inc_ms_hr  = r_ms_hr;
        w_inc_ls_hr  = r_ls_hr;
        w_inc_ms_min = r_ms_min;
        w_inc_ls_min = r_ls_min;
        if (r_ls_min >= 4'd9) begin
            w_inc_ls_min = '0;
            if (r_ms_min >= 4'd5) begin
                w_inc_ms_min = '0;
                if (r_ms_hr >= 4'd2 && r_ls_hr >= 4'd3) begin
                    w_inc_ms_hr = '0;
                    w_inc_ls_hr = '0;
                end else if (r_ls_hr >= 4'd9) begin
                    w_inc_ls_hr = '0;
                    w_inc_ms_hr = r_ms_hr + 4'd1;
                end else begin
                    w_inc_ls_hr = r_ls_hr + 4'd1;
                end
            end else begin
                w_inc_ms_min = r_ms_min + 4'd1;
            end
        end else begin
            w_inc_ls_min = r_ls_min + 4'd1;
        end
    end

`ifdef ACLK_LOAD_CHECK_EN
    always_comb begin
        w_load_ok = (bus.new_current_time_ms_hr  <= 4'd2) &&
                    (bus.new_current_time_ms_min <= 4'd5) &&
                    (bus.new_current_time_ls_min <= 4'd9) &&
                    ((bus.new_current_time_ms_hr == 4'd2) ?
                        (bus.new_current_time_ls_hr <= 4'd3) :
                        (bus.new_current_time_ls_hr <= 4'd9));
    end
`else
    assign w_load_ok = 1'b1;
`endif

    // Load has priority over the tick, whether accepted or rejected
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ms_hr    <= '0;
            r_ls_hr    <= '0;
            r_ms_min   <= '0;
            r_ls_min   <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (bus.load_new_c) begin
                if (w_load_ok) begin
                    r_ms_hr  <= bus.new_current_time_ms_hr;
                    r_ls_hr  <= bus.new_current_time_ls_hr;
                    r_ms_min <= bus.new_current_time_ms_min;
                    r_ls_min <= bus.new_current_time_ls_min;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (bus.one_minute) begin
                r_ms_hr  <= w_inc_ms_hr;
                r_ls_hr  <= w_inc_ls_hr;
                r_ms_min <= w_inc_ms_min;
                r_ls_min <= w_inc_ls_min;
            end
        end
    end

    assign bus.current_time_ms_hr  = r_ms_hr;
    assign bus.current_time_ls_hr  = r_ls_hr;
    assign bus.current_time_ms_min = r_ms_min;
    assign bus.current_time_ls_min = r_ls_min;
    assign bus.load_err            = r_load_err;

endmodule

// File: tb/tb_aclk_counter.sv
// Self-checking bench for aclk_counter: directed scenarios plus random ticks/loads
// against a minutes-of-day reference model.
module tb_aclk_counter;

    logic clock;
    logic reset;
    aclk_counter_if bus ();

    aclk_counter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned vectors;
    int unsigned miscompares;

    logic [15:0] m_time;
    logic        m_err;
    logic [15:0] w_now;

    assign w_now = {bus.current_time_ms_hr, bus.current_time_ls_hr,
                    bus.current_time_ms_min, bus.current_time_ls_min};

    function automatic logic is_legal(input logic [15:0] t);
        int h;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) &&
               (t[3:0] <= 4'd9) && (h <= 23);
    endfunction

    function automatic logic load_accepted(input logic [15:0] t);
`ifdef ACLK_LOAD_CHECK_EN
        return is_legal(t);
`else
        return (t === t);
`endif
    endfunction

    // Legal times advance as minutes-of-day; illegal digits follow the per-digit recovery rules
    function automatic logic [15:0] ref_tick(input logic [15:0] t);
        int mins, h2, m2;
        logic [3:0] a, b, c, d;
        if (is_legal(t)) begin
            mins = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
                   int'(t[7:4]) * 10 + int'(t[3:0]);
            mins = (mins + 1) % 1440;
            h2 = mins / 60;
            m2 = mins % 60;
            return {4'(h2 / 10), 4'(h2 % 10), 4'(m2 / 10), 4'(m2 % 10)};
        end
        {a, b, c, d} = t;
        if (d < 4'd9) return {a, b, c, d + 4'd1};
        if (c < 4'd5) return {a, b, c + 4'd1, 4'd0};
        if (a >= 4'd2 && b >= 4'd3) return 16'h0000;
        if (b >= 4'd9) return {a + 4'd1, 4'd0, 4'd0, 4'd0};
        return {a, b + 4'd1, 4'd0, 4'd0};
    endfunction

    task automatic cycle(input logic ld, input logic tk, input logic [15:0] d);
        bus.load_new_c = ld;
        bus.one_minute = tk;
        {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
         bus.new_current_time_ms_min, bus.new_current_time_ls_min} = d;
        @(posedge clock);
        #1;
        m_err = 1'b0;
        if (ld) begin
            if (load_accepted(d)) m_time = d;
            else m_err = 1'b1;
        end else if (tk) begin
            m_time = ref_tick(m_time);
        end
        bus.load_new_c = 1'b0;
        bus.one_minute = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if (w_now !== 16'h0000 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h err=%b, expected 0000 err=0", w_now, bus.load_err);
        end
        bus.load_new_c = 1'b1;
        bus.one_minute = 1'b1;
        {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
         bus.new_current_time_ms_min, bus.new_current_time_ls_min} = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (w_now !== 16'h0000 || bus.load_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ignores_inputs: got %h err=%b, expected 0000 err=0", w_now, bus.load_err);
            end
        end
        bus.load_new_c = 1'b0;
        bus.one_minute = 1'b0;
        reset = 1'b0;
        m_time = 16'h0000;
        m_err = 1'b0;
        cycle(1'b0, 1'b1, 16'h0000);
        vectors++;
        if (w_now !== 16'h0001) begin
            miscompares++;
            $display("FAIL reset_first_tick: got %h, expected 0001", w_now);
        end
    endtask

    task automatic test_load;
        cycle(1'b1, 1'b0, 16'h1234);
        vectors++;
        if (w_now !== 16'h1234 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL load_1234: got %h err=%b, expected 1234 err=0", w_now, bus.load_err);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0000);
        vectors++;
        if (w_now !== 16'h1237) begin
            miscompares++;
            $display("FAIL load_then_3_ticks: got %h, expected 1237", w_now);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] loads [3];
        logic [15:0] exps  [3];
        cycle(1'b1, 1'b0, 16'h2358);
        cycle(1'b0, 1'b1, 16'h0000);
        vectors++;
        if (w_now !== 16'h2359) begin
            miscompares++;
            $display("FAIL wrap_2359: got %h, expected 2359", w_now);
        end
        loads = '{16'h2359, 16'h0959, 16'h1959};
        exps  = '{16'h0000, 16'h1000, 16'h2000};
        for (int i = 0; i < 3; i++) begin
            if (i != 0) cycle(1'b1, 1'b0, loads[i]);
            cycle(1'b0, 1'b1, 16'h0000);
            vectors++;
            if (w_now !== exps[i]) begin
                miscompares++;
                $display("FAIL wrap_from_%h: got %h, expected %h", loads[i], w_now, exps[i]);
            end
        end
    endtask

    task automatic test_collision;
        cycle(1'b1, 1'b1, 16'h0815);
        vectors++;
        if (w_now !== 16'h0815) begin
            miscompares++;
            $display("FAIL collision_load_wins: got %h, expected 0815", w_now);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0000);
        vectors++;
        if (w_now !== 16'h0820) begin
            miscompares++;
            $display("FAIL held_tick_5: got %h, expected 0820", w_now);
        end
    endtask

    task automatic test_load_check;
        cycle(1'b1, 1'b0, 16'h1000);
`ifdef ACLK_LOAD_CHECK_EN
        cycle(1'b1, 1'b1, 16'h2400);
        vectors++;
        if (w_now !== 16'h1000 || bus.load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_2400: got %h err=%b, expected 1000 err=1", w_now, bus.load_err);
        end
        cycle(1'b0, 1'b0, 16'h0000);
        vectors++;
        if (w_now !== 16'h1000 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_one_cycle: got %h err=%b, expected 1000 err=0", w_now, bus.load_err);
        end
        cycle(1'b1, 1'b0, 16'h2359);
        vectors++;
        if (w_now !== 16'h2359 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_2359: got %h err=%b, expected 2359 err=0", w_now, bus.load_err);
        end
`else
        cycle(1'b1, 1'b0, 16'h2469);
        vectors++;
        if (w_now !== 16'h2469 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL verbatim_2469: got %h err=%b, expected 2469 err=0", w_now, bus.load_err);
        end
        cycle(1'b0, 1'b1, 16'h0000);
        vectors++;
        if (w_now !== 16'h0000 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL recover_2469: got %h err=%b, expected 0000 err=0", w_now, bus.load_err);
        end
`endif
    endtask

    task automatic test_async_reset;
        cycle(1'b1, 1'b0, 16'h1234);
        #3;
        bus.one_minute = 1'b1;
        reset = 1'b1;
        #1;
        vectors++;
        if (w_now !== 16'h0000 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %h err=%b, expected 0000 err=0", w_now, bus.load_err);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (w_now !== 16'h0000) begin
                miscompares++;
                $display("FAIL async_reset_hold: got %h, expected 0000", w_now);
            end
        end
        reset = 1'b0;
        bus.one_minute = 1'b0;
        m_time = 16'h0000;
        m_err = 1'b0;
        cycle(1'b1, 1'b0, 16'h0730);
        vectors++;
        if (w_now !== 16'h0730) begin
            miscompares++;
            $display("FAIL post_reset_load: got %h, expected 0730", w_now);
        end
    endtask

    task automatic test_random;
        logic        ld, tk;
        logic [15:0] d;
        int          h, m;
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                h = int'($urandom_range(0, 23));
                m = int'($urandom_range(0, 59));
                d = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
            end else begin
                d = 16'($urandom);
            end
            cycle(ld, tk, d);
            vectors++;
            if (w_now !== m_time || bus.load_err !== m_err) begin
                miscompares++;
                $display("FAIL random_%0d: got %h err=%b, expected %h err=%b", i, w_now, bus.load_err, m_time, m_err);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_time = 16'h0000;
        m_err = 1'b0;
        reset = 1'b1;
        bus.load_new_c = 1'b0;
        bus.one_minute = 1'b0;
        bus.new_current_time_ms_hr  = '0;
        bus.new_current_time_ls_hr  = '0;
        bus.new_current_time_ms_min = '0;
        bus.new_current_time_ls_min = '0;
        test_reset();
        test_load();
        test_wrap();
        test_collision();
        test_load_check();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aclk_counter.md
AclK_COUNTER -- requirements
Module: aclk_counter

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 one_minute  input  1  minute-tick pulse, sampled on clock.
REQ-005 load_new_c  input  1  load request for current time, sampled on clock.
REQ-006 new_current_time_ms_hr, new_current_time_ls_hr, new_current_time_ms_min, new_current_time_ls_min  input  4 each  BCD load digits.
REQ-007 current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  output  4 each  registered BCD current time; these feed the display stage.
REQ-008 load_err  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-009 The time register SHALL hold four 4-bit BCD digits representing HH:MM in 24-hour format, 00:00 to 23:59.
REQ-010 All outputs SHALL be driven directly from flops, with no combinational path from input to output.
REQ-011 If load_new_c=1 at a clock edge, the register SHALL take the new_current_time_* digits at that edge, giving one-cycle latency.
REQ-012 If one_minute=1 and load_new_c=0 at a clock edge, the time SHALL advance by one minute at that edge.
REQ-013 If load_new_c and one_minute are both 1, the load SHALL win and the tick SHALL be dropped (no increment of the loaded value).
REQ-014 If one_minute stays high for N consecutive edges, the time SHALL advance N minutes; no edge detection is applied.
REQ-015 Increment, ls_min: if >=9, it SHALL become 0 and carry; else it SHALL add 1.
REQ-016 Increment, ms_min: on carry, if >=5 it SHALL become 0 and carry to hours; else it SHALL add 1.
REQ-017 Increment, hours: on carry, if ms_hr>=2 and ls_hr>=3, hours SHALL become 00 (day wrap).
REQ-018 Otherwise, if ls_hr>=9, ls_hr SHALL become 0 and ms_hr SHALL add 1.
REQ-019 Otherwise, ls_hr SHALL add 1.
REQ-020 The >= comparisons SHALL make any out-of-range digit converge to a legal value on its next increment; no X or lock-up states are permitted.
REQ-021 23:59 + tick SHALL give 00:00.
REQ-022 09:59 + tick SHALL give 10:00.
REQ-023 19:59 + tick SHALL give 20:00.
REQ-024 load_err SHALL be 0 whenever REQ-029 does not apply.

Reset
REQ-025 While reset=1, all current_time_* outputs SHALL be 4'd0 (00:00) and load_err SHALL be 0, asynchronously and independent of clock.
REQ-026 Reset asserted mid-increment or mid-load SHALL override; the first action after reset release SHALL be taken on the first clock edge with reset=0.
REQ-027 Inputs SHALL be ignored while reset=1.

Configuration
REQ-028 Macro ACLK_LOAD_CHECK_EN SHALL select load validation.
REQ-029 Defined: a load SHALL be accepted only if all of the following hold: ms_hr<=2; ls_hr<=9 (<=3 when ms_hr==2); ms_min<=5; ls_min<=9.
REQ-030 Defined: a rejected load SHALL leave the time unchanged, drop any simultaneous tick, and pulse load_err=1 for exactly one cycle.
REQ-031 Not defined: loads SHALL be taken verbatim, load_err SHALL be tied to 0, and REQ-020 SHALL recover illegal values.

Verification
REQ-032 Reset: assert reset asynchronously mid-cycle with time at 12:34 -> outputs show 00:00 immediately; hold until release.
REQ-033 Load: load_new_c=1 with digits 1,2,3,4 for one cycle -> 12:34 on the next edge; then 3 ticks -> 12:37.
REQ-034 Wrap chain: load 23:58, then 2 ticks -> 23:59, then 00:00; load 09:59 + tick -> 10:00; load 19:59 + tick -> 20:00.
REQ-035 Collision: load 08:15 and one_minute=1 in the same cycle -> 08:15 (tick dropped); ticks held 5 cycles -> 08:20.
REQ-036 With ACLK_LOAD_CHECK_EN: from 10:00, load 2,4,0,0 -> time stays 10:00 and load_err pulses for one cycle; load 2,3,5,9 -> accepted, load_err=0.
REQ-037 Without ACLK_LOAD_CHECK_EN: load 2,4,6,9 then tick -> 00:00 (per REQ-017/015/016); load_err remains 0 throughout.
